// File: rtl/rst_gen_pkg.sv
// Shared types for the board reset request generator.
package rst_gen_pkg;

  typedef enum logic [1:0] {
    RST_POR = 2'd0,
    RST_BTN = 2'd1,
    RST_SW  = 2'd2,
    RST_WDT = 2'd3
  } rst_cause_e;

  typedef enum logic [1:0] {
    ASSERT  = 2'd0,
    HOLDOFF = 2'd1,
    IDLE    = 2'd2
  } rst_gen_state_e;

  // Counter width for a count that must reach n-1 without wrapping.
  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bank for asynchronous level inputs.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             gclk_i,
  input  logic             grst_n_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // First stage may go metastable; second stage is the only one used downstream.
  always_ff @(posedge gclk_i or negedge grst_n_i) begin
    if (!grst_n_i) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/reset_request_generator.sv
// Board reset request generator: merges a debounced button, a software
// request and (with RST_GEN_WATCHDOG_EN defined) a watchdog into one
// stretched active-low reset pulse with re-trigger holdoff, and records
// the cause of the last reset.
module reset_request_generator
  import rst_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int PULSE_CYCLES    = 64,
  parameter int HOLDOFF_CYCLES  = 256,
  parameter int WDT_CYCLES      = 1048576
) (
  input  logic       ext_clk_100_in,
  input  logic       ext_rst_low_in,
  input  logic       btn_rst_in,
  input  logic       sw_rst_req_in,
  input  logic       wdt_kick_in,
  output logic       rst_low_out,
  output logic [1:0] rst_cause_out,
  output logic       busy_out
);

  localparam int DB_W = cnt_w(DEBOUNCE_CYCLES);
  localparam int PL_W = cnt_w(PULSE_CYCLES);
  localparam int HO_W = cnt_w(HOLDOFF_CYCLES);
  localparam logic [DB_W-1:0] DB_TERM = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PL_W-1:0] PL_TERM = PL_W'(PULSE_CYCLES - 1);
  localparam logic [HO_W-1:0] HO_TERM = HO_W'(HOLDOFF_CYCLES - 1);

  logic btn_s, sw_s;
  logic btn_trig, sw_trig, wdt_trig;

  rst_gen_state_e state_q, state_d;
  rst_cause_e     cause_q, cause_d;
  logic [PL_W-1:0] pulse_cnt_q, pulse_cnt_d;
  logic [HO_W-1:0] hold_cnt_q, hold_cnt_d;
  logic rst_low_q, busy_q;

`ifdef RST_GEN_WATCHDOG_EN
  localparam int NSYNC = 3;
  logic [NSYNC-1:0] async_in, sync_out;
  logic kick_s;
  assign async_in = {wdt_kick_in, sw_rst_req_in, btn_rst_in};
  assign kick_s   = sync_out[2];
`else
  localparam int NSYNC = 2;
  logic [NSYNC-1:0] async_in, sync_out;
  logic unused_kick;
  assign async_in    = {sw_rst_req_in, btn_rst_in};
  assign unused_kick = wdt_kick_in;
`endif

  sync_2ff #(.WIDTH(NSYNC)) u_sync (
    .gclk_i   (ext_clk_100_in),
    .grst_n_i (ext_rst_low_in),
    .d_i      (async_in),
    .q_o      (sync_out)
  );

  assign btn_s = sync_out[0];
  assign sw_s  = sync_out[1];

  // ---------------- debounce and edge detect ----------------
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic btn_pressed_q, btn_pressed_d, btn_pressed_prev_q;
  logic sw_prev_q;

  // Run-length counter of high button samples, saturating at the terminal value.
  always_comb begin
    db_cnt_d = '0;
    if (btn_s) db_cnt_d = (db_cnt_q == DB_TERM) ? db_cnt_q : db_cnt_q + DB_W'(1);
  end

  assign btn_pressed_d = btn_s && (db_cnt_q == DB_TERM);
  assign btn_trig      = btn_pressed_q & ~btn_pressed_prev_q;
  assign sw_trig       = sw_s & ~sw_prev_q;

  // Debounce state and edge-detect history.
  always_ff @(posedge ext_clk_100_in or negedge ext_rst_low_in) begin
    if (!ext_rst_low_in) begin
      db_cnt_q           <= '0;
      btn_pressed_q      <= 1'b0;
      btn_pressed_prev_q <= 1'b0;
      sw_prev_q          <= 1'b0;
    end else begin
      db_cnt_q           <= db_cnt_d;
      btn_pressed_q      <= btn_pressed_d;
      btn_pressed_prev_q <= btn_pressed_q;
      sw_prev_q          <= sw_s;
    end
  end

  // ---------------- watchdog ----------------
`ifdef RST_GEN_WATCHDOG_EN
  localparam int WD_W = cnt_w(WDT_CYCLES);
  localparam logic [WD_W-1:0] WD_TERM = WD_W'(WDT_CYCLES - 1);

  logic [WD_W-1:0] wdt_cnt_q, wdt_cnt_d;
  logic wdt_armed_q, wdt_armed_d;
  logic kick_prev_q, kick;

  assign kick     = kick_s ^ kick_prev_q;
  assign wdt_trig = (state_q == IDLE) && wdt_armed_q && (wdt_cnt_q == WD_TERM);

  // Count idle cycles since the last kick; armed state drops on any new reset.
  always_comb begin
    wdt_cnt_d = '0;
    if (state_q == IDLE && !kick)
      wdt_cnt_d = (wdt_armed_q && wdt_cnt_q != WD_TERM) ? wdt_cnt_q + WD_W'(1) : wdt_cnt_q;
    if (state_q == IDLE && state_d == ASSERT) wdt_armed_d = 1'b0;
    else                                      wdt_armed_d = wdt_armed_q | kick;
  end

  // Watchdog registers.
  always_ff @(posedge ext_clk_100_in or negedge ext_rst_low_in) begin
    if (!ext_rst_low_in) begin
      wdt_cnt_q   <= '0;
      wdt_armed_q <= 1'b0;
      kick_prev_q <= 1'b0;
    end else begin
      wdt_cnt_q   <= wdt_cnt_d;
      wdt_armed_q <= wdt_armed_d;
      kick_prev_q <= kick_s;
    end
  end
`else
  assign wdt_trig = 1'b0;
`endif

  // ---------------- FSM ----------------
  // Next state: stretch the pulse, wait out the quiet holdoff, then accept one trigger.
  always_comb begin
    state_d     = state_q;
    cause_d     = cause_q;
    pulse_cnt_d = '0;
    hold_cnt_d  = '0;
    unique case (state_q)
      ASSERT: begin
        if (pulse_cnt_q == PL_TERM) state_d = HOLDOFF;
        else                        pulse_cnt_d = pulse_cnt_q + PL_W'(1);
      end
      HOLDOFF: begin
        if (btn_s || sw_s)             hold_cnt_d = '0;
        else if (hold_cnt_q == HO_TERM) state_d   = IDLE;
        else                           hold_cnt_d = hold_cnt_q + HO_W'(1);
      end
      IDLE: begin
        if (btn_trig || wdt_trig || sw_trig) begin
          state_d = ASSERT;
          if (btn_trig)      cause_d = RST_BTN;
          else if (wdt_trig) cause_d = RST_WDT;
          else               cause_d = RST_SW;
        end
      end
      default: state_d = ASSERT;
    endcase
  end

  // State, counters and registered output decodes.
  always_ff @(posedge ext_clk_100_in or negedge ext_rst_low_in) begin
    if (!ext_rst_low_in) begin
      state_q     <= ASSERT;
      cause_q     <= RST_POR;
      pulse_cnt_q <= '0;
      hold_cnt_q  <= '0;
      rst_low_q   <= 1'b0;
      busy_q      <= 1'b1;
    end else begin
      state_q     <= state_d;
      cause_q     <= cause_d;
      pulse_cnt_q <= pulse_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      rst_low_q   <= (state_d != ASSERT);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign rst_low_out   = rst_low_q;
  assign rst_cause_out = cause_q;
  assign busy_out      = busy_q;

endmodule

// File: doc/reset_request_generator.md
# reset_request_generator

Generates the board-level active-low reset request that feeds the clock/reset controller's external reset input, running entirely in the ext_clk_100_in domain. It merges three reset sources into one stretched, glitch-free reset pulse with guaranteed minimum width and a re-trigger holdoff: a debounced push button, a software request and an optional watchdog. The block also records which source caused the last reset.

## Interface
- DEBOUNCE_CYCLES, 1000: consecutive stable-high synced button cycles required to register a press (min 2)
- PULSE_CYCLES, 64: width of the generated reset pulse in ext_clk_100_in cycles (min 2)
- HOLDOFF_CYCLES, 256: quiet cycles after all sources idle before re-arming (min 1)
- WDT_CYCLES, 1048576: watchdog timeout in cycles since last kick (min 16)

Ports:
- ext_clk_100_in  in  1  100 MHz board clock
- ext_rst_low_in  in  1  board power-on reset; asynchronous, active-low
- btn_rst_in  in  1  raw push button, active-high, asynchronous, bouncy
- sw_rst_req_in  in  1  software reset request level, asynchronous to this clock
- wdt_kick_in  in  1  watchdog kick; toggle signal, any edge counts as one kick, asynchronous
- rst_low_out  out  1  generated reset request, active-low, registered
- rst_cause_out  out  2  last reset cause: 0 POR, 1 button, 2 software, 3 watchdog
- busy_out  out  1  high while in ASSERT or HOLDOFF

## Operation
- btn_rst_in, sw_rst_req_in and wdt_kick_in each pass through a 2-flop synchronizer before any use.
- Debounce: the counter increments while synced button is high and clears on any low cycle. Reaching DEBOUNCE_CYCLES-1 with button high sets btn_pressed. The trigger is the rising edge of btn_pressed only.
- Software trigger: rising edge of the synced request.
- Watchdog kick: XOR of the last two synced samples.
- States:
  - ASSERT: rst_low_out=0; pulse counter runs 0..PULSE_CYCLES-1, then go to HOLDOFF.
  - HOLDOFF: rst_low_out=1; counter clears whenever synced button or synced sw request is high; after HOLDOFF_CYCLES consecutive quiet cycles go to IDLE.
  - IDLE: rst_low_out=1; any trigger goes to ASSERT and latches its cause.
- Triggers in ASSERT/HOLDOFF are ignored and never queued; rst_cause_out is unchanged by them.
- Simultaneous triggers in IDLE: cause priority is button > watchdog > software.
- rst_cause_out changes only on entry to ASSERT.
- Counters are sized $clog2(N)+1 bits; compare against N-1; no wrap (saturate at the terminal value).

## Timing
- Reset values: rst_low_out=0, rst_cause_out=0 (POR), busy_out=1, state=ASSERT, all counters 0, synchronizers 0, watchdog disarmed.
- On ext_rst_low_in deassertion the block runs a full PULSE_CYCLES ASSERT, then HOLDOFF, with cause POR.
- Reassertion of ext_rst_low_in at any time immediately forces the reset state above.
- Software latency: synced edge detected 2 cycles after the input edge; rst_low_out falls on the following clock edge (3 edges after the input edge).
- Button latency: rst_low_out falls 2 + DEBOUNCE_CYCLES + 1 edges after a clean press begins.
- Pulse width: rst_low_out low for exactly PULSE_CYCLES cycles per trigger. For POR, the count starts at the first clock edge after deassertion.
- busy_out is a registered state decode, same cycle alignment as rst_low_out.

## Configuration
- RST_GEN_WATCHDOG_EN defined:
  - Watchdog arms on the first detected kick; disarms on entry to ASSERT.
  - While armed in IDLE, the counter increments per cycle and clears on each kick.
  - Reaching WDT_CYCLES-1 is a watchdog trigger. The counter holds at 0 outside IDLE.
- RST_GEN_WATCHDOG_EN undefined:
  - wdt_kick_in is unused and its synchronizer and counter are not built.
  - Cause 3 is never produced.

## Structure
- Shared package rst_gen_pkg: rst_cause_e enum (RST_POR, RST_BTN, RST_SW, RST_WDT) and rst_gen_state_e enum (ASSERT, HOLDOFF, IDLE).
- One sub-module: sync_2ff (parameterized width), instanced for button, software request and kick.
- Debounce, watchdog and FSM stay in the top module.

## Test plan
- POR: release ext_rst_low_in -> rst_low_out low exactly 64 cycles, rst_cause_out=0, busy_out low after 64+256 cycles.
- Bouncy button: 10 pulses of 50 cycles high/50 low, then held high 1200 cycles -> a single reset, asserted 1003 edges after the stable-high start, cause=1.
- Software request high while in HOLDOFF, held 500 cycles, then low -> no new reset; IDLE reached 256 cycles after release. A later rising edge -> reset with cause=2.
- Simultaneous button-debounce completion and sw edge in the same IDLE cycle -> one 64-cycle pulse, cause=1.
- RST_GEN_WATCHDOG_EN with WDT_CYCLES=1024: one kick then none -> reset 1024 cycles later, cause=3. Kicks every 500 cycles -> no reset.
- ext_rst_low_in asserted mid-ASSERT at pulse count 30 -> outputs return to reset values. After release, a full 64-cycle pulse with cause=0.
